// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   state_e      : sweep/run state encoding (ST_CLEAR, ST_RUN)
//   DATA_W_DEF   : default word width
//   ADDR_W_DEF   : default address width (DEPTH = 2**ADDR_W)
//   MAX_RD       : largest supported number of read ports
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_RD     = 4;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of regfile_mp.
// Optional feature macro: REGFILE_MP_BYPASS_EN (write-first forwarding).
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset (clears the output register)
//   run_i       array is in normal operation; output held at 0 otherwise
//   addr_i      read address
//   arr_data_i  current (pre-write) array content at addr_i
//   we0_i/waddr0_i/wdata0_i, we1_i/waddr1_i/wdata1_i
//               qualified write ports, present only with REGFILE_MP_BYPASS_EN
//   rd_data_o   registered read data (1-cycle latency)
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] arr_data_i,
`ifdef REGFILE_MP_BYPASS_EN
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] waddr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] waddr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
`endif
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_comb begin
        rd_data_d = arr_data_i;
`ifdef REGFILE_MP_BYPASS_EN
        // Port 1 is checked first so it wins when both ports hit this address.
        if (we1_i && (waddr1_i == addr_i)) begin
            rd_data_d = wdata1_i;
        end else if (we0_i && (waddr0_i == addr_i)) begin
            rd_data_d = wdata0_i;
        end
`endif
        // Zero check comes last so address 0 is never forwarded.
        if (addr_i == '0) begin
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (!run_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with two write
// ports (port 1 has priority), NUM_RD registered read ports, r0 hardwired
// to zero and a post-reset clear sweep.
// Optional feature macro: REGFILE_MP_BYPASS_EN (write-first reads).
// Ports:
//   clk      clock, all logic on posedge
//   rst_n    synchronous active-low reset
//   rd_addr  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  packed registered read data, port i at [i*DATA_W +: DATA_W]
//   we0/waddr0/wdata0  write port 0
//   we1/waddr1/wdata1  write port 1 (wins on address conflict)
//   busy     high while in reset or while the clear sweep runs
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    output logic                     busy
);

    localparam int DEPTH = 1 << ADDR_W;

    if ((NUM_RD < 1) || (NUM_RD > MAX_RD)) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD out of range 1..MAX_RD");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic run;
    logic wr_en0, wr_en1;

    assign run    = (state_q == ST_RUN);
    assign wr_en0 = run && we0 && (waddr0 != '0);
    assign wr_en1 = run && we1 && (waddr1 != '0);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (&clr_ptr_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= (state_d == ST_CLEAR);
        end
    end

    // Array is left untouched on reset edges; the sweep zeroes it afterwards.
    // Port 1 is written last so it wins on an address conflict.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else begin
                if (wr_en0) mem_q[waddr0] <= wdata0;
                if (wr_en1) mem_q[waddr1] <= wdata1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] arr_rd;

        assign addr   = rd_addr[i*ADDR_W +: ADDR_W];
        assign arr_rd = mem_q[addr];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .run_i      (run),
            .addr_i     (addr),
            .arr_data_i (arr_rd),
`ifdef REGFILE_MP_BYPASS_EN
            .we0_i      (wr_en0),
            .waddr0_i   (waddr0),
            .wdata0_i   (wdata0),
            .we1_i      (wr_en1),
            .waddr1_i   (waddr1),
            .wdata1_i   (wdata1),
`endif
            .rd_data_o  (rd_data[i*DATA_W +: DATA_W])
        );
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration DUT
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic        busy;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .busy(busy)
    );

    // Wide / shallow / four-read-port DUT
    logic         p_rst_n;
    logic [11:0]  p_rd_addr;
    logic [255:0] p_rd_data;
    logic         p_we0, p_we1;
    logic [2:0]   p_waddr0, p_waddr1;
    logic [63:0]  p_wdata0, p_wdata1;
    logic         p_busy;

    regfile_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4)) dut_p (
        .clk(clk), .rst_n(p_rst_n), .rd_addr(p_rd_addr), .rd_data(p_rd_data),
        .we0(p_we0), .waddr0(p_waddr0), .wdata0(p_wdata0),
        .we1(p_we1), .waddr1(p_waddr1), .wdata1(p_wdata1), .busy(p_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the default DUT: contents become all-zero once 32
    // un-reset edges have elapsed; reads are 0 until then.
    logic [31:0] m_mem [32];
    logic [31:0] m_rd  [2];
    logic        m_busy = 1'b1;
    int          m_clr_left = 32;

    task automatic model_edge();
        logic [4:0]  a;
        logic [31:0] v;
        if (!rst_n) begin
            m_clr_left = 32;
            m_busy     = 1'b1;
            m_rd[0]    = '0;
            m_rd[1]    = '0;
        end else if (m_clr_left > 0) begin
            m_clr_left--;
            if (m_clr_left == 0) begin
                for (int k = 0; k < 32; k++) m_mem[k] = '0;
            end
            m_busy  = (m_clr_left != 0);
            m_rd[0] = '0;
            m_rd[1] = '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = rd_addr[p*5 +: 5];
                v = m_mem[a];
`ifdef REGFILE_MP_BYPASS_EN
                if (we1 && waddr1 == a) v = wdata1;
                else if (we0 && waddr0 == a) v = wdata0;
`endif
                if (a == 0) v = '0;
                m_rd[p] = v;
            end
            if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    // Ticks from now until busy is seen low (bounded at 100).
    task automatic ticks_to_idle(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 100);
    endtask

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n;
        logic [31:0] exp_same;

        vecs[0] = '{1'b1, 5'd7,  32'h1111_1111, 1'b1, 5'd7,  32'h2222_2222, 5'd1,  5'd2,  32'h0,         32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd7,  5'd0,  32'h2222_2222, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd7,  5'd7,  32'h2222_2222, 32'h2222_2222};
        vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
        vecs[4] = '{1'b1, 5'd3,  32'hA,         1'b1, 5'd4,  32'hC,         5'd7,  5'd1,  32'h2222_2222, 32'h0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd3,  5'd4,  32'hA,         32'hC};
        vecs[6] = '{1'b1, 5'd31, 32'h1234_5678, 1'b1, 5'd1,  32'h8765_4321, 5'd4,  5'd3,  32'hC,         32'hA};
        vecs[7] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd31, 5'd1,  32'h1234_5678, 32'h8765_4321};
        vecs[8] = '{1'b1, 5'd3,  32'h5,         1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 32'h1234_5678, 32'h1234_5678};
        vecs[9] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd3,  5'd0,  32'h5,         32'h0};

        rst_n = 0; rd_addr = '0; idle_writes();
        p_rst_n = 0; p_rd_addr = '0; p_we0 = 0; p_we1 = 0;
        p_waddr0 = 0; p_waddr1 = 0; p_wdata0 = 0; p_wdata1 = 0;

        // 1. Reset, clear sweep, writes ignored during CLEAR
        tick();
        chk("reset_busy", busy, 1'b1);
        chk("reset_rd",   rd_data, 64'h0);
        tick(); tick();
        rst_n = 1;
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEAD_BEEF;
        we1 = 1; waddr1 = 6; wdata1 = 32'hCAFE_F00D;
        rd_addr = {5'd6, 5'd5};
        ticks_to_idle(n);
        chk("clear_cycles", n, 32);
        chk("clear_rd_held0", rd_data, 64'h0);
        idle_writes();
        for (int a = 1; a < 32; a++) begin
            rd_addr = {5'(32 - a), 5'(a)};
            tick();
            chk($sformatf("cleared_r%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("cleared_r%0d", 32 - a), rd_data[63:32], 32'h0);
        end

        // 2/3. Table: conflict writes, r0 writes, general traffic
        for (int i = 0; i < 10; i++) begin
            we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
            we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            tick();
            chk($sformatf("vec%0d_rd0", i), rd_data[31:0],  vecs[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd_data[63:32], vecs[i].e1);
        end
        idle_writes();

        // 4. Same-edge read/write of r3
        we0 = 1; waddr0 = 3; wdata0 = 32'hA; rd_addr = {5'd0, 5'd7};
        tick();
        we0 = 0; we1 = 1; waddr1 = 3; wdata1 = 32'hB; rd_addr = {5'd0, 5'd3};
        tick();
`ifdef REGFILE_MP_BYPASS_EN
        exp_same = 32'hB;
`else
        exp_same = 32'hA;
`endif
        chk("same_edge_rw", rd_data[31:0], exp_same);
        idle_writes();
        tick();
        chk("same_edge_next", rd_data[31:0], 32'hB);

        // 5. Reset mid-run
        we0 = 1; waddr0 = 9; wdata0 = 32'h55; rd_addr = {5'd0, 5'd1};
        tick();
        idle_writes(); rd_addr = {5'd9, 5'd9};
        tick();
        chk("r9_written", rd_data, {32'h55, 32'h55});
        rst_n = 0; we0 = 1; waddr0 = 10; wdata0 = 32'h77;
        tick();
        chk("midreset_rd",   rd_data, 64'h0);
        chk("midreset_busy", busy, 1'b1);
        rst_n = 1; idle_writes(); rd_addr = {5'd10, 5'd9};
        ticks_to_idle(n);
        chk("reclear_cycles", n, 32);
        tick();
        chk("r9_after_reclear",  rd_data[31:0],  32'h0);
        chk("r10_after_reclear", rd_data[63:32], 32'h0);

        // Randomised traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rst_n  = ($urandom_range(0, 149) != 0);
            we0    = 1'($urandom_range(0, 1));
            we1    = 1'($urandom_range(0, 1));
            waddr0 = 5'($urandom_range(0, 7));
            waddr1 = 5'($urandom_range(0, 7));
            wdata0 = $urandom;
            wdata1 = $urandom;
            rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            tick();
            chk("rand_rd0",  rd_data[31:0],  m_rd[0]);
            chk("rand_rd1",  rd_data[63:32], m_rd[1]);
            chk("rand_busy", busy, m_busy);
        end
        rst_n = 1; idle_writes();

        // 6. DATA_W=64, ADDR_W=3, NUM_RD=4
        tick();
        chk("p_reset_busy", p_busy, 1'b1);
        chk("p_reset_rd",   p_rd_data, 256'h0);
        p_rst_n = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (p_busy && n < 100);
        chk("p_clear_cycles", n, 8);
        p_we0 = 1; p_waddr0 = 1; p_wdata0 = 64'h1111_0000_0000_0001;
        p_we1 = 1; p_waddr1 = 2; p_wdata1 = 64'h2222_0000_0000_0002;
        tick();
        p_waddr0 = 3; p_wdata0 = 64'h3333_0000_0000_0003;
        p_waddr1 = 4; p_wdata1 = 64'h4444_0000_0000_0004;
        tick();
        p_we0 = 0; p_we1 = 0;
        p_rd_addr = {3'd1, 3'd2, 3'd3, 3'd4};
        tick();
        chk("p_rd0", p_rd_data[63:0],    64'h4444_0000_0000_0004);
        chk("p_rd1", p_rd_data[127:64],  64'h3333_0000_0000_0003);
        chk("p_rd2", p_rd_data[191:128], 64'h2222_0000_0000_0002);
        chk("p_rd3", p_rd_data[255:192], 64'h1111_0000_0000_0001);
        p_rd_addr = {3'd2, 3'd0, 3'd7, 3'd1};
        tick();
        chk("p_rd0_b", p_rd_data[63:0],    64'h1111_0000_0000_0001);
        chk("p_rd1_b", p_rd_data[127:64],  64'h0);
        chk("p_rd2_b", p_rd_data[191:128], 64'h0);
        chk("p_rd3_b", p_rd_data[255:192], 64'h2222_0000_0000_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read CPU regfile.
- Provides NUM_RD read ports and two write ports (WB pipe + load/long-latency pipe), with registered 1-cycle reads.
- Register 0 is hardwired to zero.
- After reset, a clear state machine sweeps every entry to zero and reports completion on `busy`.
- Sits between the decode stage (reads) and the writeback stage (writes) of the pipelined core.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of read ports; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port i at [i*DATA_W +: DATA_W].
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- busy  out  1  high while reset is asserted or the clear sweep is running.

Behaviour:
- Reset state: with rst_n sampled low at a posedge:
  - state = CLEAR, clr_ptr = 0.
  - All rd_data = 0; busy = 1.
  - Array contents are not touched in that cycle.
- CLEAR state (rst_n high):
  - Each posedge writes 0 to entry clr_ptr, then clr_ptr increments.
  - When clr_ptr == DEPTH-1, the last entry is written, state goes to RUN, and busy drops at that same edge.
  - Total sweep: DEPTH cycles after rst_n rises.
  - we0/we1 are ignored throughout CLEAR; rd_data stays 0.
- RUN state:
  - Writes: at a posedge, weN && waddrN != 0 writes wdataN.
  - Both ports writing the same address: port 1 wins; port 0 data is dropped.
  - Writes to address 0 are discarded.
  - Reads: rd_data[i] is registered at the posedge that samples rd_addr[i]; latency is 1 cycle.
  - rd_addr[i] == 0 returns 0 regardless of any write.
  - Read/write same address, same edge: see Optional Feature.
- Reset mid-operation: rst_n low in RUN or CLEAR forces CLEAR with clr_ptr = 0 at that edge and rd_data = 0. Pending writes in that cycle are dropped.
- busy is registered; no combinational path from any input to any output.
- States: CLEAR, RUN. CLEAR goes to RUN on sweep completion; any state goes to CLEAR on rst_n low.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined (write-first): a same-edge write to the address being read forwards the write data into rd_data. If both ports hit that address, port 1 data is forwarded.
- Undefined (read-first): rd_data returns the pre-write array value; the new value is visible one cycle later.
- Address 0 is never bypassed in either mode.

Decomposition:
- Package regfile_pkg holds:
  - the state encoding (ST_CLEAR, ST_RUN);
  - default DATA_W/ADDR_W constants;
  - MAX_RD = 4.
- One sub-module: regfile_rd_port. Instantiated NUM_RD times via generate, it contains:
  - the zero-address check;
  - the bypass comparators/mux (when the macro is defined);
  - the output register.

Test Plan:
1. Clear sweep: hold rst_n low 3 cycles, then release.
   - busy must stay high for exactly 32 cycles after release.
   - Afterwards, reading every address 1..31 must return 0.
   - Pre-load garbage: a write of 0xDEAD_BEEF to r5 issued during CLEAR is ignored, and r5 reads 0.
2. Dual write with conflict:
   - we0 = we1 = 1, waddr0 = waddr1 = 7, wdata0 = 0x1111_1111, wdata1 = 0x2222_2222.
   - Next-cycle read of r7 (result one cycle later) must be 0x2222_2222.
3. Zero register: write 0xFFFF_FFFF to r0 on both ports, then read r0 on all ports -> 0.
4. Same-edge read/write: r3 = 0xA, then write 0xB to r3 while reading r3.
   - With REGFILE_MP_BYPASS_EN: rd_data = 0xB.
   - Without it: rd_data = 0xA, then 0xB on the next read.
5. Reset mid-run: write 0x55 to r9, then assert rst_n low for 1 cycle.
   - rd_data must go to 0 and busy must rise at that edge.
   - After 32 clear cycles, r9 reads 0.
6. Parameter sweep: instantiate DATA_W = 64, ADDR_W = 3, NUM_RD = 4.
   - Clear must take 8 cycles.
   - All 4 ports reading distinct registers must return independent values simultaneously.
